// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM (Moore decode of registered state)
// Optional MC_MEM_WAIT_EN adds a mem_ready handshake that stalls FETCH/MEMRD/MEMWR.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MC_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] EXTOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  state_t state_q;
  state_t state_d;
  logic   ready;
  logic   unused_inputs;

  // funct is consumed by the ALU decoder and zero by the PC-enable logic, not here.
  assign unused_inputs = ^{funct, zero};

`ifdef MC_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    PCSource    = 2'b00;
    EXTOp       = EXT_SIGN;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = ready;
        ALUSrcB = 2'b01;
        PCWrite = ready;
        state_d = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut before op is known.
        ALUSrcB = 2'b11;
        EXTOp   = EXT_SIGN;
        case (op)
          OP_LW, OP_SW:           state_d = S_MEMADR;
          OP_RTYPE:               state_d = S_EXEC;
          OP_BEQ:                 state_d = S_BRANCH;
          OP_J:                   state_d = S_JUMP;
          OP_JAL:                 state_d = S_JAL;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg   = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = ready;
        state_d    = ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegDst     = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC was already advanced in FETCH, so it is the return address.
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
        instr_done = 1'b1;
      end
      S_IEXEC, S_IWB: begin
        case (op)
          OP_ORI: begin
            ALUOp = ALU_OR;
            EXTOp = EXT_ZERO;
          end
          OP_LUI: begin
            ALUOp = ALU_OR;
            EXTOp = EXT_LUI;
          end
          default: begin
            ALUOp = ALU_ADD;
            EXTOp = EXT_SIGN;
          end
        endcase
        if (state_q == S_IEXEC) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = S_IWB;
        end else begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl against an instruction-level model
// Define MC_MEM_WAIT_EN for both RTL and bench to exercise the memory handshake.
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
`ifdef MC_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] RegDst, MemtoReg;
  logic       RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource, EXTOp;
  logic [3:0] state;
  logic       instr_done, illegal;

  int checks = 0;
  int errors = 0;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
`ifdef MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .EXTOp(EXTOp), .state(state),
    .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw;
    logic [1:0] regdst, m2r;
    logic       rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc, extop;
    logic       done, ill;
  } ctl_t;

  typedef int iq_t[$];

  ctl_t act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, EXTOp, instr_done, illegal};

  logic [5:0] legal_ops [9] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0d, 6'h0f};

  function automatic bit is_legal(input logic [5:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // Expected state walk of one instruction with an always-ready memory.
  function automatic iq_t exp_seq(input logic [5:0] o);
    case (o)
      6'h23:               return '{0, 1, 2, 3, 4};
      6'h2b:               return '{0, 1, 2, 5};
      6'h00:               return '{0, 1, 6, 7};
      6'h04:               return '{0, 1, 8};
      6'h02:               return '{0, 1, 9};
      6'h03:               return '{0, 1, 12};
      6'h08, 6'h0d, 6'h0f: return '{0, 1, 10, 11};
      default:             return '{0, 1};
    endcase
  endfunction

  function automatic ctl_t exp_ctl(input int s, input logic [5:0] o, input logic rdy);
    ctl_t c = '0;
    case (s)
      0:  begin c.mrd = 1; c.irw = rdy; c.pcw = rdy; c.srcb = 2'b01; end
      1:  begin c.srcb = 2'b11; c.ill = !is_legal(o); end
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.iord = 1; c.mrd = 1; end
      4:  begin c.m2r = 2'b01; c.rw = 1; c.done = 1; end
      5:  begin c.iord = 1; c.mwr = 1; c.done = rdy; end
      6:  begin c.srca = 1; c.aluop = 3'b111; end
      7:  begin c.regdst = 2'b01; c.rw = 1; c.done = 1; end
      8:  begin c.srca = 1; c.aluop = 3'b001; c.pcwc = 1; c.pcsrc = 2'b01; c.done = 1; end
      9:  begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
      12: begin c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1; c.regdst = 2'b10; c.m2r = 2'b10; c.done = 1; end
      10, 11: begin
        c.aluop = (o == 6'h08) ? 3'b000 : 3'b010;
        c.extop = (o == 6'h0d) ? 2'b01 : (o == 6'h0f) ? 2'b10 : 2'b00;
        if (s == 10) begin c.srca = 1; c.srcb = 2'b10; end
        else begin c.rw = 1; c.done = 1; end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic bit any_enable();
    return PCWrite | PCWriteCond | IRWrite | MemRead | MemWrite | RegWrite | instr_done | illegal;
  endfunction

  // mode 0: always ready; 1: random ready; 2: stall stall_n cycles in stall_state.
  task automatic run_instr(input logic [5:0] o, input int mode, input int stall_state,
                           input int stall_n, input int exp_cycles, input string name);
    iq_t seq = exp_seq(o);
    int idx = 0, cyc = 0, dones = 0, ills = 0, stalls = 0, stalled_here = 0;
    logic rdy;
    ctl_t e;
    op = o;
    funct = 6'($urandom);
    while (idx < seq.size() && cyc < 200) begin
      zero = 1'($urandom);
      rdy = 1'b1;
`ifdef MC_MEM_WAIT_EN
      if (mode == 1) rdy = ($urandom_range(3) != 0);
      else if (mode == 2 && seq[idx] == stall_state && stalled_here < stall_n) rdy = 1'b0;
      mem_ready = rdy;
`endif
      #1;
      checks++;
      if (state !== 4'(seq[idx])) begin
        errors++;
        $display("FAIL %s state cyc%0d: got %0d expected %0d", name, cyc, state, seq[idx]);
      end
      e = exp_ctl(seq[idx], o, rdy);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s controls cyc%0d st%0d: got %h expected %h", name, cyc, seq[idx], act, e);
      end
      dones += int'(instr_done);
      ills  += int'(illegal);
      if (!rdy && (seq[idx] == 0 || seq[idx] == 3 || seq[idx] == 5)) begin
        stalls++;
        if (seq[idx] == stall_state) stalled_here++;
      end else begin
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL %s end_state: got %0d expected 0", name, state);
    end
    checks++;
    if (dones != (is_legal(o) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected %0d", name, dones, is_legal(o) ? 1 : 0);
    end
    checks++;
    if (ills != (is_legal(o) ? 0 : 1)) begin
      errors++;
      $display("FAIL %s illegal_count: got %0d expected %0d", name, ills, is_legal(o) ? 0 : 1);
    end
    if (exp_cycles < 0) exp_cycles = seq.size() + stalls;
    checks++;
    if (cyc != exp_cycles) begin
      errors++;
      $display("FAIL %s cycles: got %0d expected %0d", name, cyc, exp_cycles);
    end
  endtask

  task automatic chk_quiet(input string name, input logic [3:0] exp_state);
    checks++;
    if (any_enable() !== 1'b0 || state !== exp_state) begin
      errors++;
      $display("FAIL %s: got state %0d enables %b expected state %0d enables 0",
               name, state, any_enable(), exp_state);
    end
  endtask

  task automatic chk_fetch(input string name);
    checks++;
    if (state !== 4'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
      errors++;
      $display("FAIL %s: got state %0d PCWrite %b IRWrite %b expected 0 1 1",
               name, state, PCWrite, IRWrite);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset_initial", 4'd0);
    reset = 1'b0; #1;
    chk_fetch("reset_release");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd6) begin
      errors++;
      $display("FAIL reset_reach_exec: got %0d expected 6", state);
    end
    reset = 1'b1; #1;
    chk_quiet("reset_in_exec", 4'd6);
    @(posedge clk); #1;
    chk_quiet("reset_cycle1", 4'd0);
    @(posedge clk); #1;
    chk_quiet("reset_cycle2", 4'd0);
    reset = 1'b0; #1;
    chk_fetch("reset_exec_release");
    op = 6'h23;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1; #1;
    chk_quiet("reset_in_memwb", 4'd4);
    @(posedge clk); #1;
    op = 6'h3f;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    chk_quiet("reset_in_illegal_decode", 4'd1);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    chk_fetch("reset_final_release");
  endtask

  task automatic test_lw();      run_instr(6'h23, 0, 0, 0, 5, "lw"); endtask
  task automatic test_sw();      run_instr(6'h2b, 0, 0, 0, 4, "sw"); endtask
  task automatic test_rtype();   run_instr(6'h00, 0, 0, 0, 4, "rtype"); endtask
  task automatic test_imm();
    run_instr(6'h08, 0, 0, 0, 4, "addi");
    run_instr(6'h0d, 0, 0, 0, 4, "ori");
    run_instr(6'h0f, 0, 0, 0, 4, "lui");
  endtask
  task automatic test_jumps();
    run_instr(6'h02, 0, 0, 0, 3, "j");
    run_instr(6'h03, 0, 0, 0, 3, "jal");
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      op = 6'h04;
      zero = 1'(z);
      repeat (2) @(posedge clk);
      #1;
      zero = 1'(z); #1;
      checks++;
      if (state !== 4'd8 || PCWriteCond !== 1'b1 || PCSource !== 2'b01 || ALUOp !== 3'b001) begin
        errors++;
        $display("FAIL beq_zero%0d: got st %0d pcwc %b pcsrc %b aluop %b expected 8 1 01 001",
                 z, state, PCWriteCond, PCSource, ALUOp);
      end
      @(posedge clk); #1;
      chk_fetch($sformatf("beq_zero%0d_return", z));
    end
    run_instr(6'h04, 0, 0, 0, 3, "beq_model");
  endtask

  task automatic test_illegal();
    run_instr(6'h3f, 0, 0, 0, 2, "illegal_3f");
    run_instr(6'h05, 0, 0, 0, 2, "illegal_bne");
  endtask

  task automatic test_back_to_back();
    logic [5:0] o;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(4) == 0) o = 6'($urandom);
      else o = legal_ops[$urandom_range(8)];
      run_instr(o, 1, 0, 0, -1, $sformatf("rand%0d_op%02h", n, o));
    end
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    run_instr(6'h2b, 2, 5, 3, 7, "sw_wait_memwr");
    run_instr(6'h23, 2, 3, 2, 7, "lw_wait_memrd");
    run_instr(6'h00, 2, 0, 3, 7, "rtype_wait_fetch");
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_imm();
    test_jumps();
    test_beq();
    test_illegal();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS core. It sequences a shared-memory, multi-cycle version of the datapath (PC, IM/DM, RF, ALU, EXT) through fetch, decode, execute, memory and write-back states. It replaces the single-cycle combinational decoder when instruction and data memory share one port. It drives all mux selects, write enables and ALU/EXT opcodes from a registered Moore state, decoded from the opcode latched in the instruction register.

## Interface
Parameters:
- none (all encodings fixed below)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns FSM to FETCH
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake (present only with MC_MEM_WAIT_EN)
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero=1
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- RegDst  out  2  00=rt, 01=rd, 10=$31
- MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC
- RegWrite  out  1  RF write enable
- ALUSrcA  out  1  0=PC, 1=rs data
- ALUSrcB  out  2  00=rt data, 01=const 4, 10=ext imm, 11=ext imm<<2
- ALUOp  out  3  000 ADD, 001 SUB, 010 OR, 111 decode from funct
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- EXTOp  out  2  00 sign, 01 zero, 10 lui (imm<<16)
- state  out  4  current state code (debug)
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  one-cycle pulse when DECODE sees unsupported opcode

## Operation
- States (4-bit codes): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, JAL=12. Codes 13–15 are unreachable; if entered, next state is FETCH.
- FETCH: IorD=0, MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, EXTOp=00 (branch target into ALUOut). Next state by op:
  - 100011 lw, 101011 sw → MEMADR
  - 000000 R-type → EXEC
  - 000100 beq → BRANCH
  - 000010 j → JUMP
  - 000011 jal → JAL
  - 001000 addi, 001101 ori, 001111 lui → IEXEC
  - any other opcode → FETCH with illegal=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, EXTOp=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Next is MEMWB.
- MEMWB: RegDst=00, MemtoReg=01, RegWrite=1, instr_done=1. Next is FETCH.
- MEMWR: IorD=1, MemWrite=1, instr_done=1. Next is FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next is RWB.
- RWB: RegDst=01, MemtoReg=00, RegWrite=1, instr_done=1. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01, instr_done=1. Next is FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next is FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4), instr_done=1. Next is FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. Selects by op:
  - addi: ALUOp=ADD, EXTOp=00
  - ori: ALUOp=OR, EXTOp=01
  - lui: ALUOp=OR, EXTOp=10 (rs=$0 by encoding)
  - Next is IWB.
- IWB: RegDst=00, MemtoReg=00, RegWrite=1, instr_done=1. EXTOp/ALUOp are held as in IEXEC. Next is FETCH.
- Every signal not listed for a state is 0.

## Timing
- Outputs are purely combinational decodes of the registered state (plus op in DECODE/IEXEC/IWB/MEMADR). No output depends on zero.
- On reset=1 at a rising edge, state becomes FETCH (0). While reset is high, all write enables and strobes (PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite) are forced to 0, and instr_done=0, illegal=0.
- Reset mid-instruction abandons the instruction; no partial write occurs after the reset edge.
- Cycles per instruction, zero-wait:
  - lw: 5
  - sw, R-type, addi, ori, lui: 4
  - beq, j, jal: 3
  - illegal opcode: 2
- instr_done is high for exactly one cycle per instruction, in the cycle whose rising edge commits the final write.

## Configuration
- MC_MEM_WAIT_EN defined:
  - The mem_ready port exists.
  - FETCH, MEMRD and MEMWR hold their state while mem_ready=0, with MemRead/MemWrite held asserted.
  - PCWrite and IRWrite in FETCH are gated with mem_ready.
  - instr_done in MEMWR is gated with mem_ready.
  - Each wait cycle adds one cycle of latency.
- MC_MEM_WAIT_EN undefined:
  - No mem_ready port; memory is treated as always ready.
  - Latencies are exactly those listed in Timing.

## Test plan
- Reset: hold reset 2 cycles during EXEC → state=0, all enables 0 while reset is high; next cycle FETCH with PCWrite=1, IRWrite=1.
- lw (op=100011) → state sequence 0,1,2,3,4,0; RegWrite=1, MemtoReg=01 only in state 4; instr_done pulses once at cycle 5.
- beq with zero=1 then zero=0 → sequence 0,1,8,0 in both cases; PCWriteCond=1, PCSource=01, ALUOp=001 in state 8.
- jal (op=000011) → sequence 0,1,12,0; in state 12 RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1, PCSource=10.
- Illegal op=111111 → sequence 0,1,0; illegal=1 for one cycle in DECODE; no RegWrite or MemWrite asserted.
- With MC_MEM_WAIT_EN, sw with mem_ready low for 3 cycles in MEMWR → state stays 5 for 4 cycles with MemWrite=1; instr_done pulses only in the cycle mem_ready=1.
